mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported word memory between the pipeline's instruction-fetch port and its load/store port. It is a single-outstanding-transaction arbiter with a req/gnt/rvalid handshake on each requester side and a req/rvalid handshake on the memory side. Loads and stores win by default, and a starvation counter guarantees fetch progress. It sits between the fetch/memory stages of the 5-stage RV32I core and a shared instruction+data RAM.

## Interface
- AW, default 12: memory word-address width; memory address = byte address [AW+1:2].
- MAX_DBURST, default 4: maximum consecutive data grants while fetch is waiting.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_adr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched word.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  4  byte write enables; 4'b0000 means read.
- dm_adr  in  32  data byte address.
- dm_wdata  in  32  store data, already lane-aligned.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  one-cycle pulse: load data valid or store complete.
- dm_rdata  out  32  load word; 0 on store completion.
- mem_req  out  1  one-cycle memory command strobe.
- mem_we  out  4  byte enables for the command.
- mem_adr  out  AW  word address.
- mem_wdata  out  32  write data.
- mem_rvalid  in  1  memory completion: read data valid, or write ack.
- mem_rdata  in  32  memory read data.

## Operation
- FSM states: IDLE and WAIT. Owner register: NONE, IF, or DM.
- IDLE with any request:
  - Pick a winner combinationally.
  - Assert its gnt and mem_req in the same cycle. mem_adr, mem_we and mem_wdata are driven from the winner's inputs.
  - Latch the owner and move to WAIT.
- Fetch grants drive mem_we = 0 and mem_wdata = 0.
- Arbitration when both request:
  - DM wins unless dcnt == MAX_DBURST, in which case IF wins.
  - A single requester always wins.
- dcnt, 0..MAX_DBURST, saturating:
  - +1 on a DM grant while if_req = 1.
  - Cleared on any IF grant.
  - Cleared in IDLE when if_req = 0.
- WAIT:
  - mem_req = 0 and both gnt = 0; new requests are held off.
  - On mem_rvalid: register mem_rdata, or 0 if the owner was a DM store, into the owner's rdata. Pulse the owner's rvalid next cycle. Return to IDLE.
- IDLE in the cycle after the return (the rvalid cycle) may grant again.
- mem_rvalid while in IDLE is ignored and produces no rvalid pulse.
- Addresses and data only need to be stable in the gnt cycle. Requesters may change them afterwards.
- Reset, including mid-WAIT:
  - Return to IDLE; owner = NONE; dcnt = 0.
  - All outputs 0, including both rdata buses.
  - A mem_rvalid from an abandoned transaction that arrives after reset release is ignored, because the FSM is in IDLE.

## Timing
- Request in cycle 0 → gnt and mem_req in cycle 0 → mem_rvalid no earlier than cycle 1 → rvalid in cycle mem_rvalid + 1.
- Minimum latency from gnt to rvalid is 2 cycles.
- Peak throughput: one transaction per 2 cycles (grant in the rvalid cycle).
- if_gnt and dm_gnt are never high together. At most one rvalid is high per cycle.
- gnt is combinational from req and registered state. rvalid and rdata are registered.
- Memory latency is unbounded; the arbiter waits in WAIT indefinitely.

## Structure
- Package rv_mem_pkg holds:
  - the arb_state_t enum (IDLE, WAIT);
  - the owner_t enum (NONE, IF, DM);
  - WORD_W = 32;
  - the WE_NONE constant.
- Optional sub-module mem_arb_pick: purely combinational priority plus starvation picker. Inputs if_req, dm_req, dcnt_full; outputs grant_if, grant_dm.
- Everything else (FSM, dcnt, response registers) is flat in mem_arbiter.

## Test plan
- Single fetch:
  - Stimulus: if_req with if_adr = 0x0000_0010; memory returns 0x0000_0013 after 1 cycle.
  - Required: if_gnt and mem_req in cycle 0 with mem_adr = 0x004; mem_rvalid in cycle 1; if_rvalid in cycle 2 with if_rdata = 0x0000_0013.
- Store then load:
  - Stimulus: dm_we = 4'b1111, dm_adr = 0x40, dm_wdata = 0xDEAD_BEEF; then a read of 0x40.
  - Required: store completes with dm_rvalid and dm_rdata = 0; load returns 0xDEAD_BEEF.
- Starvation:
  - Stimulus: if_req and dm_req held high continuously with MAX_DBURST = 4.
  - Required: grant order DM, DM, DM, DM, IF, DM, …
- Simultaneous requests:
  - Stimulus: both request in the same IDLE cycle with dcnt = 0.
  - Required: only dm_gnt is asserted.
- Reset mid-WAIT:
  - Stimulus: assert reset while waiting; the memory then returns mem_rvalid after reset release.
  - Required: all outputs 0 during reset; no rvalid pulse afterwards; the next request is granted normally.
- Long latency:
  - Stimulus: memory delays mem_rvalid by 10 cycles while dm_req is held.
  - Required: no second gnt during WAIT; dm_gnt arrives in the cycle if_rvalid pulses.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package rv_mem_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam logic [3:0]  WE_NONE = 4'b0000;

    // Arbiter FSM: IDLE may grant, WAIT holds one outstanding transaction.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    // Which requester owns the outstanding memory transaction.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DM   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection: data side has priority unless the
// starvation counter is full while fetch is also requesting.
module mem_arb_pick (
    input  logic if_req,
    input  logic dm_req,
    input  logic dcnt_full,
    output logic grant_if,
    output logic grant_dm
);

    // Priority pick with starvation override.
    always_comb begin
        grant_dm = dm_req && !(if_req && dcnt_full);
        grant_if = if_req && !grant_dm;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one word memory between the fetch port
// and the load/store port. Grants are combinational from IDLE; responses are
// registered and pulse one cycle after the memory completion.
module mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned AW         = 12,
    parameter int unsigned MAX_DBURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    // Instruction fetch side
    input  logic              if_req,
    input  logic [31:0]       if_adr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    // Load/store side
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [31:0]       dm_adr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [WORD_W-1:0] dm_rdata,
    // Memory side
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [AW-1:0]     mem_adr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int unsigned DCW = $clog2(MAX_DBURST + 1);

    arb_state_t        r_state,    w_state_nxt;
    owner_t            r_owner,    w_owner_nxt;
    logic              r_is_store, w_is_store_nxt;
    logic [DCW-1:0]    r_dcnt,     w_dcnt_nxt;
    logic              w_rsp_take;

    logic              r_if_rvalid;
    logic [WORD_W-1:0] r_if_rdata;
    logic              r_dm_rvalid;
    logic [WORD_W-1:0] r_dm_rdata;

    logic              w_if_req_v;
    logic              w_dm_req_v;
    logic              w_dcnt_full;
    logic              w_pick_if;
    logic              w_pick_dm;
    logic              w_unused;

    // Requests are masked during reset so every output is low while it is held.
    assign w_if_req_v  = if_req && !reset;
    assign w_dm_req_v  = dm_req && !reset;
    assign w_dcnt_full = (r_dcnt == DCW'(MAX_DBURST));

    // Byte-offset and upper address bits do not reach the word memory.
    assign w_unused = ^{if_adr[31:AW+2], if_adr[1:0], dm_adr[31:AW+2], dm_adr[1:0]};

    mem_arb_pick u_pick (
        .if_req    (w_if_req_v),
        .dm_req    (w_dm_req_v),
        .dcnt_full (w_dcnt_full),
        .grant_if  (w_pick_if),
        .grant_dm  (w_pick_dm)
    );

    // State, owner and starvation counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= NONE;
            r_is_store <= 1'b0;
            r_dcnt     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_is_store <= w_is_store_nxt;
            r_dcnt     <= w_dcnt_nxt;
        end
    end

    // Next-state, grant and memory command generation.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_is_store_nxt = r_is_store;
        w_dcnt_nxt     = r_dcnt;
        w_rsp_take     = 1'b0;
        if_gnt         = 1'b0;
        dm_gnt         = 1'b0;
        mem_req        = 1'b0;
        mem_we         = WE_NONE;
        mem_adr        = '0;
        mem_wdata      = '0;

        case (r_state)
            IDLE: begin
                if (!w_if_req_v) begin
                    w_dcnt_nxt = '0;
                end
                if (w_pick_dm) begin
                    dm_gnt         = 1'b1;
                    mem_req        = 1'b1;
                    mem_we         = dm_we;
                    mem_adr        = dm_adr[AW+1:2];
                    mem_wdata      = dm_wdata;
                    w_state_nxt    = WAIT;
                    w_owner_nxt    = DM;
                    w_is_store_nxt = (dm_we != WE_NONE);
                    // Only grants that bypass a waiting fetch count toward starvation.
                    if (w_if_req_v && !w_dcnt_full) begin
                        w_dcnt_nxt = r_dcnt + DCW'(1);
                    end
                end else if (w_pick_if) begin
                    if_gnt         = 1'b1;
                    mem_req        = 1'b1;
                    mem_adr        = if_adr[AW+1:2];
                    w_state_nxt    = WAIT;
                    w_owner_nxt    = IF;
                    w_is_store_nxt = 1'b0;
                    w_dcnt_nxt     = '0;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_rsp_take  = 1'b1;
                    w_state_nxt = IDLE;
                    w_owner_nxt = NONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = NONE;
            end
        endcase
    end

    // Response capture: steer completion data to the owning port as a one-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_rsp_take && (r_owner == IF);
            r_dm_rvalid <= w_rsp_take && (r_owner == DM);
            if (w_rsp_take && (r_owner == IF)) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_rsp_take && (r_owner == DM)) begin
                r_dm_rdata <= r_is_store ? '0 : mem_rdata;
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_rvalid = r_dm_rvalid;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural word RAM of variable latency.
module tb_mem_arbiter;

    localparam int unsigned AW   = 12;
    localparam int unsigned MAXB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [31:0]   if_adr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          dm_req;
    logic [3:0]    dm_we;
    logic [31:0]   dm_adr;
    logic [31:0]   dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [31:0]   dm_rdata;
    logic          mem_req;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_wdata;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .MAX_DBURST(MAXB)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_adr     (if_adr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_adr     (dm_adr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int unsigned w);
        return 32'hC0DE_0000 | w;
    endfunction

    // Behavioural RAM: command seen mid-cycle, completion mem_lat cycles later.
    logic [31:0] ram [0:4095];
    int unsigned mem_lat = 1;
    bit          m_pend  = 1'b0;
    int unsigned m_cnt   = 0;
    logic [31:0] m_data  = '0;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = pat(i);
        ram[4] = 32'h0000_0013;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                m_data = (mem_we == 4'b0000) ? ram[mem_adr] : 32'hA5A5_A5A5;
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) ram[mem_adr][8*b +: 8] = mem_wdata[8*b +: 8];
                m_pend = 1'b1;
                m_cnt  = mem_lat;
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = m_data;
                    m_pend     = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        if_q[$];
    exp_t        dm_q[$];
    int unsigned gnt_log[$];
    bit          log_en = 1'b0;
    int unsigned rv_cnt = 0;

    // Response monitor: pops the scoreboard on every rvalid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (if_gnt && dm_gnt) chk("gnt_excl", 1, 0);
            if (if_rvalid && dm_rvalid) chk("rvalid_excl", 1, 0);
            if (log_en) begin
                if (if_gnt) gnt_log.push_back(1);
                if (dm_gnt) gnt_log.push_back(2);
            end
            if (if_rvalid || dm_rvalid) rv_cnt++;
            if (if_rvalid) begin
                if (if_q.size() == 0) chk("if_spurious", 1, 0);
                else begin
                    e = if_q.pop_front();
                    chk("if_rdata", if_rdata, e.data);
                    chk("if_lat", cyc, e.cyc);
                end
            end
            if (dm_rvalid) begin
                if (dm_q.size() == 0) chk("dm_spurious", 1, 0);
                else begin
                    e = dm_q.pop_front();
                    chk("dm_rdata", dm_rdata, e.data);
                    chk("dm_lat", cyc, e.cyc);
                end
            end
        end
    end

    // Raise a request (called just after a rising edge), wait for its grant and queue the response.
    task automatic issue(input bit is_dm, input logic [3:0] we, input logic [31:0] adr,
                         input logic [31:0] wdata, input logic [31:0] exp, input bit keep);
        bit   got;
        exp_t e;
        got = 1'b0;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_adr = adr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_adr = adr;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = is_dm ? dm_gnt : if_gnt;
        end
        if (!got) chk(is_dm ? "dm_gnt_timeout" : "if_gnt_timeout", 0, 1);
        else begin
            e.data = exp;
            e.cyc  = cyc + mem_lat + 1;
            if (is_dm) dm_q.push_back(e); else if_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (is_dm) begin
                dm_req = 1'b0; dm_adr = $urandom(); dm_wdata = $urandom(); dm_we = 4'b0000;
            end else begin
                if_req = 1'b0; if_adr = $urandom();
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (if_q.size() != 0 || dm_q.size() != 0 || m_pend); i++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain_if", if_q.size(), 0);
        chk("drain_dm", dm_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, mem_adr}, 0);
        chk({tag, "_rdata"}, {if_rdata, dm_rdata}, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp_order[7];
        int unsigned early;
        int unsigned snap;
        bit          saw;
        bit          got;
        exp_t        e;

        reset = 1'b1;
        if_req = 1'b1; if_adr = 32'h10;
        dm_req = 1'b1; dm_we = 4'b0000; dm_adr = 32'h40; dm_wdata = '0;

        // Reset with both requests raised: nothing may be granted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single fetch with one-cycle memory latency.
        mem_lat = 1;
        if_req = 1'b1; if_adr = 32'h0000_0010;
        @(negedge clk);
        chk("f_if_gnt", if_gnt, 1);
        chk("f_dm_gnt", dm_gnt, 0);
        chk("f_mem_req", mem_req, 1);
        chk("f_mem_adr", mem_adr, 12'h004);
        chk("f_mem_we", mem_we, 0);
        chk("f_mem_wdata", mem_wdata, 0);
        e.data = 32'h0000_0013; e.cyc = cyc + 2;
        if_q.push_back(e);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("f_wait_no_rvalid", if_rvalid, 0);
        drain();

        // Store, partial store, then loads back.
        issue(1, 4'b1111, 32'h40, 32'hDEAD_BEEF, 32'h0, 0);
        issue(1, 4'b0011, 32'h44, 32'h1234_5678, 32'h0, 0);
        drain();
        chk("ram_store", ram[16], 32'hDEAD_BEEF);
        issue(1, 4'b0000, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);
        issue(1, 4'b0000, 32'h44, 32'h0, 32'hC0DE_5678, 0);
        drain();

        // Both requesters held high: data wins until the burst limit, then fetch.
        mem_lat = 1;
        gnt_log.delete();
        log_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    issue(1, 4'b0000, 32'h100 + 4*i, 32'h0, pat(32'h40 + i), i < 4);
            end
            begin
                for (int i = 0; i < 2; i++)
                    issue(0, 4'b0000, 32'h200 + 4*i, 32'h0, pat(32'h80 + i), i < 1);
            end
        join
        log_en = 1'b0;
        exp_order = '{2, 2, 2, 2, 1, 2, 1};
        chk("starve_len", gnt_log.size(), 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("starve_order%0d", i), (i < gnt_log.size()) ? gnt_log[i] : 0, exp_order[i]);
        drain();

        // Long latency: data request held off until the fetch response cycle.
        mem_lat = 10;
        issue(0, 4'b0000, 32'h300, 32'h0, pat(32'hC0), 0);
        dm_req = 1'b1; dm_we = 4'b0000; dm_adr = 32'h304;
        early = 0; saw = 1'b0; got = 1'b0;
        for (int i = 0; i < 30 && !saw; i++) begin
            @(negedge clk);
            if (if_rvalid) begin
                saw = 1'b1;
                chk("ll_dm_gnt_on_rvalid", dm_gnt, 1);
                got = dm_gnt;
            end else if (dm_gnt) early++;
        end
        chk("ll_no_early_gnt", early, 0);
        chk("ll_saw_rvalid", saw, 1);
        if (got) begin
            e.data = pat(32'hC1); e.cyc = cyc + mem_lat + 1;
            dm_q.push_back(e);
        end
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        drain();

        // Reset during WAIT; the late memory completion must be ignored.
        mem_lat = 6;
        dm_req = 1'b1; dm_we = 4'b0000; dm_adr = 32'h500;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = dm_gnt;
        end
        chk("rw_gnt", got, 1);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1; if_req = 1'b1; dm_req = 1'b1;
        @(negedge clk);
        chk_all_zero("rw_rst");
        @(posedge clk);
        #1;
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        snap = rv_cnt;
        repeat (8) @(posedge clk);
        #1;
        chk("rw_no_rvalid", rv_cnt - snap, 0);
        chk("rw_mem_done", m_pend, 0);
        mem_lat = 1;
        issue(0, 4'b0000, 32'h10, 32'h0, 32'h0000_0013, 0);
        issue(1, 4'b0000, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
